// File: rtl/log_dump_ctrl.sv
// log_dump_ctrl
//   Streams the entire contents of a log memory out as a byte stream.
//   On an accepted start request, reads every word from address 0 upward.
//   Each word is sent MSB byte first over a valid/ready byte interface.
//   A start request is rejected with an error pulse unless the memory
//   holds a complete capture.
//
// Ports
//   clk                  system clock, rising edge
//   i_rst                synchronous active-high reset
//   i_start              one-cycle dump request
//   i_mem_full           log memory holds a complete capture (sampled in IDLE)
//   i_data_log_from_mem  read data from log memory
//   i_tx_ready           byte sink ready
//   o_read_log           one-cycle pulse putting the log memory in read mode
//   o_addr_log_to_mem    read address to log memory
//   o_tx_data            byte to sink
//   o_tx_valid           o_tx_data valid
//   o_busy               dump in progress
//   o_done               one-cycle pulse, dump complete
//   o_err                one-cycle pulse, start rejected
module log_dump_ctrl #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_mem_full,
  input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  input  logic                       i_tx_ready,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int NB    = BRAM_DATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  state_e                     state_q,     state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [IDX_W-1:0]           byte_idx_q,  byte_idx_d;
  logic [BRAM_DATA_WIDTH-1:0] word_q,      word_d;
  logic [CNT_W-1:0]           wait_cnt_q,  wait_cnt_d;
  logic [7:0]                 tx_data_q,   tx_data_d;
  logic                       tx_valid_q,  tx_valid_d;
  logic                       read_log_q,  read_log_d;
  logic                       busy_q,      busy_d;
  logic                       done_q,      done_d;
  logic                       err_q,       err_d;

  // Byte idx of a word, index 0 being the most significant byte.
  function automatic logic [7:0] sel_byte(input logic [BRAM_DATA_WIDTH-1:0] w,
                                          input logic [IDX_W-1:0]           idx);
    logic [BRAM_DATA_WIDTH-1:0] sh;
    sh = w >> (8 * (NB - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wait_cnt_d = wait_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    read_log_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Pulse outputs are computed for the state being entered, so they appear
    // registered in the same cycle the FSM occupies that state.
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_mem_full) begin
            state_d    = S_REQ;
            read_log_d = 1'b1;
            addr_d     = '0;
            byte_idx_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end

      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          word_d     = i_data_log_from_mem;
          tx_data_d  = sel_byte(i_data_log_from_mem, '0);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_SEND: begin
        tx_valid_d = 1'b1;
        if (i_tx_ready) begin
          if (byte_idx_q != IDX_W'(NB - 1)) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            tx_data_d  = sel_byte(word_q, byte_idx_q + IDX_W'(1));
          end else if (addr_q != {BRAM_ADDR_WIDTH{1'b1}}) begin
            addr_d     = addr_q + BRAM_ADDR_WIDTH'(1);
            byte_idx_d = '0;
            wait_cnt_d = '0;
            tx_valid_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            // Last address: finish instead of wrapping back to 0.
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: the word register is an ordinary flop bank, not a RAM, so clearing it on reset is cheap and keeps restarts deterministic.
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      wait_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      read_log_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wait_cnt_q <= wait_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      read_log_q <= read_log_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_read_log        = read_log_q;
  assign o_addr_log_to_mem = addr_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_valid        = tx_valid_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_log_dump_ctrl.sv
// tb_log_dump_ctrl
//   Directed bench for log_dump_ctrl with an 8-word x 16-bit log memory
//   whose word at address a is 16'hA0B0 + a. Inputs change 1 time unit
//   after the rising edge; the byte monitor samples on the falling edge.
module tb_log_dump_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int RL = 2;
  localparam int NBYTES = (1 << AW) * DW / 8;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_mem_full;
  logic [DW-1:0] i_data_log_from_mem;
  logic          i_tx_ready;
  logic          o_read_log;
  logic [AW-1:0] o_addr_log_to_mem;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  always #5 clk = ~clk;

  log_dump_ctrl #(
    .BRAM_ADDR_WIDTH(AW),
    .BRAM_DATA_WIDTH(DW),
    .RD_LATENCY     (RL)
  ) dut (
    .clk                (clk),
    .i_rst              (i_rst),
    .i_start            (i_start),
    .i_mem_full         (i_mem_full),
    .i_data_log_from_mem(i_data_log_from_mem),
    .i_tx_ready         (i_tx_ready),
    .o_read_log         (o_read_log),
    .o_addr_log_to_mem  (o_addr_log_to_mem),
    .o_tx_data          (o_tx_data),
    .o_tx_valid         (o_tx_valid),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err)
  );

  // Log memory: the address launched by one edge is read out after the
  // next, i.e. data is valid RL=2 edges after the edge that drives it.
  always @(posedge clk) i_data_log_from_mem <= 16'hA0B0 + {{(DW-AW){1'b0}}, o_addr_log_to_mem};

  // ---------------------------------------------------------------- monitor
  logic [7:0] bytes[$];
  int         n_rl, n_done, n_err, n_unstable;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready) bytes.push_back(o_tx_data);
    if (o_read_log) n_rl++;
    if (o_done)     n_done++;
    if (o_err)      n_err++;
    // A stalled byte must neither change nor be withdrawn before transfer.
    if (!i_rst && prev_valid && !prev_ready && (!o_tx_valid || o_tx_data != prev_data))
      n_unstable++;
    prev_valid = o_tx_valid;
    prev_ready = i_tx_ready;
    prev_data  = o_tx_data;
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bytes.delete();
    n_rl = 0; n_done = 0; n_err = 0; n_unstable = 0;
  endtask

  // Compares the captured stream against A0,B0,A0,B1,...,A0,B7.
  task automatic check_seq(input string tag);
    int bad;
    bad = 0;
    check({tag, "_count"}, bytes.size(), NBYTES);
    for (int i = 0; i < bytes.size() && i < NBYTES; i++) begin
      logic [7:0] exp;
      exp = (i % 2 == 0) ? 8'hA0 : 8'(8'hB0 + i / 2);
      if (bytes[i] !== exp) bad++;
    end
    check({tag, "_bytes_wrong"}, bad, 0);
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_valid"}, o_tx_valid, 0);
    check({tag, "_data"},  o_tx_data, 0);
    check({tag, "_addr"},  o_addr_log_to_mem, 0);
    check({tag, "_rdlog"}, o_read_log, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_err"},   o_err, 0);
  endtask

  // Runs one dump: start at cycle 0, then cycles until o_done or budget.
  // restart_at / rst_at >= 0 inject a start pulse / reset once that many
  // bytes have transferred.
  task automatic run_dump(input bit bp, input int restart_at, input int rst_at,
                          output int cyc_rl, output int cyc_valid, output bit timed_out);
    bit pulsed;
    int cyc;
    clear_mon();
    cyc_rl = -1; cyc_valid = -1; pulsed = 0; timed_out = 1;
    i_mem_full = 1'b1;
    i_tx_ready = 1'b1;
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
    for (cyc = 1; cyc < BUDGET; cyc++) begin
      if (o_read_log && cyc_rl < 0)  cyc_rl = cyc;
      if (o_tx_valid && cyc_valid < 0) cyc_valid = cyc;
      if (o_done) begin
        timed_out = 0;
        break;
      end
      i_tx_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (rst_at >= 0 && bytes.size() == rst_at) begin
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        timed_out = 0;
        return;
      end
      if (restart_at >= 0 && !pulsed && bytes.size() == restart_at) begin
        i_start = 1'b1;
        pulsed  = 1;
      end else begin
        i_start = 1'b0;
      end
      step();
    end
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
    if (timed_out) check("dump_timeout", 1, 0);
  endtask

  initial begin
    int  cyc_rl, cyc_valid;
    bit  to;

    i_rst = 1'b1; i_start = 1'b0; i_mem_full = 1'b0; i_tx_ready = 1'b0;
    step();
    step();
    check_outputs_reset("reset");
    i_rst = 1'b0;
    step();
    check("idle_busy", o_busy, 0);

    // Full dump, sink always ready, with latency measurement.
    run_dump(0, -1, -1, cyc_rl, cyc_valid, to);
    check("lat_read_log_cycle", cyc_rl, 1);
    check("lat_first_valid_cycle", cyc_valid, 4);
    check("full_done_busy", o_busy, 1);
    step();
    check_seq("full");
    check("full_read_log_pulses", n_rl, 1);
    check("full_done_pulses", n_done, 1);
    check("full_done_one_cycle", o_done, 0);
    check("full_busy_after", o_busy, 0);
    check("full_last_addr", o_addr_log_to_mem, 7);

    // Backpressure: random 30% ready.
    run_dump(1, -1, -1, cyc_rl, cyc_valid, to);
    step();
    check_seq("bp");
    check("bp_unstable_stall", n_unstable, 0);
    check("bp_done_pulses", n_done, 1);

    // Rejected start.
    repeat (2) step();
    clear_mon();
    i_mem_full = 1'b0;
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
    check("rej_err", o_err, 1);
    check("rej_busy", o_busy, 0);
    check("rej_read_log", o_read_log, 0);
    step();
    check("rej_err_one_cycle", o_err, 0);
    repeat (6) step();
    check("rej_no_bytes", bytes.size(), 0);
    check("rej_err_pulses", n_err, 1);

    // Start while busy at byte 5.
    run_dump(0, 5, -1, cyc_rl, cyc_valid, to);
    step();
    check_seq("busy_start");
    check("busy_start_done_pulses", n_done, 1);
    check("busy_start_read_log_pulses", n_rl, 1);
    repeat (8) step();
    check("busy_start_idle", o_busy, 0);

    // Reset mid-dump at byte 7.
    run_dump(0, -1, 7, cyc_rl, cyc_valid, to);
    check_outputs_reset("mid_rst");
    repeat (8) step();
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_still_idle", o_busy, 0);
    run_dump(0, -1, -1, cyc_rl, cyc_valid, to);
    step();
    check_seq("after_rst");
    check("after_rst_first_valid", cyc_valid, 4);

    // Reset dominates a simultaneous start.
    i_mem_full = 1'b1;
    i_rst      = 1'b1;
    i_start    = 1'b1;
    step();
    i_rst   = 1'b0;
    i_start = 1'b0;
    check("rst_dom_busy", o_busy, 0);
    check("rst_dom_read_log", o_read_log, 0);
    step();
    check("rst_dom_busy_next", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/log_dump_ctrl.md
LOG_DUMP_CTRL -- requirements
Module: log_dump_ctrl

Interface
REQ-001 SHALL have parameter BRAM_ADDR_WIDTH, default 15, log-memory address width (depth = 2^BRAM_ADDR_WIDTH words).
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 16, log word width; integer multiple of 8, >= 8.
REQ-003 SHALL have parameter RD_LATENCY, default 2, clock cycles from address drive to valid read data; >= 1.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_start  input  1  one-cycle dump request.
REQ-007 SHALL have port i_mem_full  input  1  log memory holds a complete capture.
REQ-008 SHALL have port i_data_log_from_mem  input  BRAM_DATA_WIDTH  read data from log memory.
REQ-009 SHALL have port i_tx_ready  input  1  byte sink ready.
REQ-010 SHALL have port o_read_log  output  1  one-cycle pulse putting log memory in read mode.
REQ-011 SHALL have port o_addr_log_to_mem  output  BRAM_ADDR_WIDTH  read address to log memory.
REQ-012 SHALL have port o_tx_data  output  8  byte to sink.
REQ-013 SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-014 SHALL have port o_busy  output  1  dump in progress.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse, dump complete.
REQ-016 SHALL have port o_err  output  1  one-cycle pulse, start rejected (memory not full).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, SEND, DONE.
REQ-018 IDLE: i_start=1 and i_mem_full=1 -> REQ; i_start=1 and i_mem_full=0 -> o_err=1 next cycle, stay IDLE; else stay.
REQ-019 REQ (one cycle): o_read_log=1, address=0, byte index=0 -> WAIT.
REQ-020 WAIT: hold address exactly RD_LATENCY cycles, then register i_data_log_from_mem into internal word register -> SEND.
REQ-021 SEND: o_tx_valid=1, o_tx_data=byte of word register selected by byte index, MSB byte first (index 0 = bits [W-1:W-8]).
REQ-022 Transfer SHALL occur on a rising edge with o_tx_valid=1 and i_tx_ready=1; o_tx_data and o_tx_valid SHALL stay stable until then; i_tx_ready while o_tx_valid=0 is ignored.
REQ-023 On transfer, not last byte of word: byte index+1, stay SEND, next byte presented the following cycle.
REQ-024 On transfer of last byte, address < 2^BRAM_ADDR_WIDTH-1: address+1, byte index=0 -> WAIT.
REQ-025 On transfer of last byte, address = 2^BRAM_ADDR_WIDTH-1: -> DONE; address SHALL NOT wrap to 0 during a dump.
REQ-026 DONE (one cycle): o_done=1 -> IDLE.
REQ-027 o_busy=1 in REQ, WAIT, SEND, DONE; 0 in IDLE.
REQ-028 i_start SHALL be ignored outside IDLE; i_mem_full SHALL be sampled only in IDLE.
REQ-029 Total bytes per dump SHALL be 2^BRAM_ADDR_WIDTH * BRAM_DATA_WIDTH/8, addresses strictly ascending.
REQ-030 o_tx_valid SHALL be 0 in all states except SEND; o_read_log, o_done, o_err SHALL never exceed one cycle.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 i_rst=1 SHALL on next edge force IDLE, o_addr_log_to_mem=0, o_tx_data=0, o_tx_valid=0, o_read_log=0, o_busy=0, o_done=0, o_err=0, byte index=0, word register=0.
REQ-033 Reset mid-dump SHALL abort without o_done; a subsequent i_start restarts from address 0.
REQ-034 i_rst SHALL dominate i_start in the same cycle.

Verification (bench: BRAM_ADDR_WIDTH=3, BRAM_DATA_WIDTH=16, RD_LATENCY=2, memory model with 2-cycle latency, word[a]=16'hA0B0+a)
REQ-035 Full dump, i_tx_ready=1 constantly: i_mem_full=1, i_start pulse -> one o_read_log pulse, 16 bytes A0,B0,A0,B1,...,A0,B7, then one o_done pulse, o_busy low after.
REQ-036 Backpressure: i_tx_ready random 30% duty -> identical 16-byte sequence; o_tx_data never changes while o_tx_valid=1 and i_tx_ready=0.
REQ-037 Rejected start: i_mem_full=0, i_start pulse -> o_err=1 for one cycle, o_busy=0, o_read_log=0, no bytes.
REQ-038 Start while busy: second i_start pulse at byte 5 -> no restart, total still 16 bytes, one o_done.
REQ-039 Reset mid-dump: i_rst at byte 7 -> all outputs at reset values next cycle, no o_done; new i_start -> full 16-byte dump from A0,B0.
REQ-040 Latency: i_start at cycle 0 -> o_read_log at cycle 1, first o_tx_valid at cycle 4 (REQ 1 + WAIT 2 + latch).
